// File: rtl/nearest_hit_if.sv
// Handshake bundle for nearest_hit_pipe: candidate beat in, arg-min result out.
// Parameters must match the ones given to the attached nearest_hit_pipe.
interface nearest_hit_if #(
    parameter int IDX_W  = 3,
    parameter int LENGTH = 10,
    parameter int TAG_W  = 8
);
    localparam int N = 1 << IDX_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*LENGTH-1:0]   in_bus;
    logic [N-1:0]          in_mask;
    logic [TAG_W-1:0]      in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_idx;
    logic [LENGTH-1:0]     out_min;
    logic                  out_hit;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output in_valid, in_bus, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_idx, out_min, out_hit, out_tag
    );

    modport slave (
        input  in_valid, in_bus, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_idx, out_min, out_hit, out_tag
    );
endinterface

// File: rtl/nearest_hit_pipe.sv
// Pipelined arg-min over 2**IDX_W masked hit distances, one registered tree level
// per index bit, with a single global stall driven by the output handshake.
module nearest_hit_pipe #(
    parameter int IDX_W  = 3,
    parameter int LENGTH = 10,
    parameter int TAG_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    nearest_hit_if.slave   bus
);
    localparam int N     = 1 << IDX_W;
    localparam int NODES = N - 1;
    localparam logic [LENGTH-1:0] DIST_INF = '1;

    // Nodes are stored level by level: level 1 at 0..N/2-1, the root last.
    function automatic int lvl_off(input int k);
        return N - (N >> (k - 1));
    endfunction

    logic                node_hit_q  [NODES];
    logic                node_hit_d  [NODES];
    logic [IDX_W-1:0]    node_idx_q  [NODES];
    logic [IDX_W-1:0]    node_idx_d  [NODES];
    logic [LENGTH-1:0]   node_dist_q [NODES];
    logic [LENGTH-1:0]   node_dist_d [NODES];

    logic [IDX_W:1]      vld_q;
    logic [IDX_W:1]      vld_d;
    logic [TAG_W-1:0]    tag_q [1:IDX_W];
    logic [TAG_W-1:0]    tag_d [1:IDX_W];

    logic                adv;

    assign adv          = !vld_q[IDX_W] || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin : reduce
        logic              l_hit, r_hit, pick_r, o_hit;
        logic [IDX_W-1:0]  l_idx, r_idx, o_idx;
        logic [LENGTH-1:0] l_dist, r_dist, o_dist;
        int                src, dst;

        node_hit_d  = node_hit_q;
        node_idx_d  = node_idx_q;
        node_dist_d = node_dist_q;
        l_hit = 1'b0; r_hit = 1'b0; pick_r = 1'b0; o_hit = 1'b0;
        l_idx = '0;   r_idx = '0;   o_idx = '0;
        l_dist = '0;  r_dist = '0;  o_dist = '0;
        src = 0;      dst = 0;

        for (int k = 1; k <= IDX_W; k++) begin
            for (int j = 0; j < (N >> k); j++) begin
                dst = lvl_off(k) + j;
                if (k == 1) begin
                    l_hit  = bus.in_mask[2*j];
                    r_hit  = bus.in_mask[2*j+1];
                    l_idx  = '0;
                    r_idx  = '0;
                    l_dist = bus.in_bus[(2*j)*LENGTH +: LENGTH];
                    r_dist = bus.in_bus[(2*j+1)*LENGTH +: LENGTH];
                end else begin
                    src    = lvl_off(k - 1) + 2*j;
                    l_hit  = node_hit_q[src];
                    r_hit  = node_hit_q[src+1];
                    l_idx  = node_idx_q[src];
                    r_idx  = node_idx_q[src+1];
                    l_dist = node_dist_q[src];
                    r_dist = node_dist_q[src+1];
                end

                // A real hit always beats a masked side, even at all-ones distance;
                // between two hits the strict compare keeps ties on the lower index.
                pick_r = r_hit && (!l_hit || (r_dist < l_dist));
                o_hit  = l_hit || r_hit;
                o_idx  = pick_r ? (r_idx | (IDX_W'(1) << (k - 1))) : l_idx;
                o_dist = !o_hit ? DIST_INF : (pick_r ? r_dist : l_dist);
                if ((k == IDX_W) && !o_hit) begin
                    o_idx = '0;
                end

                if (adv) begin
                    node_hit_d[dst]  = o_hit;
                    node_idx_d[dst]  = o_idx;
                    node_dist_d[dst] = o_dist;
                end
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (adv) begin
            vld_d[1] = bus.in_valid && adv;
            tag_d[1] = bus.in_tag;
            for (int k = 2; k <= IDX_W; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= IDX_W; k++) begin
                tag_q[k] <= '0;
            end
            for (int n = 0; n < NODES; n++) begin
                node_hit_q[n]  <= 1'b0;
                node_idx_q[n]  <= '0;
                node_dist_q[n] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            node_hit_q  <= node_hit_d;
            node_idx_q  <= node_idx_d;
            node_dist_q <= node_dist_d;
        end
    end

    assign bus.out_valid = vld_q[IDX_W];
    assign bus.out_idx   = node_idx_q[NODES-1];
    assign bus.out_min   = node_dist_q[NODES-1];
    assign bus.out_hit   = node_hit_q[NODES-1];
    assign bus.out_tag   = tag_q[IDX_W];
endmodule

// File: tb/tb_nearest_hit_pipe.sv
// Scoreboard bench for nearest_hit_pipe: main instance at IDX_W=3, plus IDX_W=1
// and IDX_W=5 instances sharing clock and reset for the mid-stream reset case.
module tb_nearest_hit_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    bit   sb_on = 1'b0;
    bit   lat_on = 1'b0;

    typedef struct {
        int idx;
        int mn;
        bit hit;
        int tag;
        int acc;
    } exp_t;

    exp_t sb_q[$];

    nearest_hit_if #(.IDX_W(1), .LENGTH(10), .TAG_W(8)) b1();
    nearest_hit_if #(.IDX_W(3), .LENGTH(10), .TAG_W(8)) b3();
    nearest_hit_if #(.IDX_W(5), .LENGTH(10), .TAG_W(8)) b5();

    nearest_hit_pipe #(.IDX_W(1), .LENGTH(10), .TAG_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    nearest_hit_pipe #(.IDX_W(3), .LENGTH(10), .TAG_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    nearest_hit_pipe #(.IDX_W(5), .LENGTH(10), .TAG_W(8)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [63:0] idx, input logic [63:0] mn,
                           input logic [63:0] hit, input logic [63:0] tg, input exp_t e);
        chk({tag, "_idx"}, idx, e.idx);
        chk({tag, "_min"}, mn,  e.mn);
        chk({tag, "_hit"}, hit, e.hit);
        chk({tag, "_tag"}, tg,  e.tag);
    endtask

    // Linear scan: first strictly smaller real hit wins, so ties stay on the lower index.
    function automatic exp_t model(input logic [639:0] w, input logic [63:0] m, input int n, input int tag);
        exp_t e;
        e.hit = 1'b0; e.idx = 0; e.mn = 1023; e.tag = tag; e.acc = 0;
        for (int i = 0; i < n; i++) begin
            if (m[i] && (!e.hit || int'(w[i*10 +: 10]) < e.mn)) begin
                e.hit = 1'b1;
                e.idx = i;
                e.mn  = int'(w[i*10 +: 10]);
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input int i, input int m, input bit h);
        exp_t e;
        e.idx = i; e.mn = m; e.hit = h; e.tag = 0; e.acc = 0;
        return e;
    endfunction

    function automatic logic [79:0] pk(input int d0, input int d1, input int d2, input int d3,
                                       input int d4, input int d5, input int d6, input int d7);
        return {10'(d7), 10'(d6), 10'(d5), 10'(d4), 10'(d3), 10'(d2), 10'(d1), 10'(d0)};
    endfunction

    function automatic logic [639:0] rnd_bus();
        logic [639:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i*10 +: 10] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
        end
        return r;
    endfunction

    task automatic send(input logic [79:0] d, input logic [7:0] m, input logic [7:0] t, input exp_t e);
        bit ok = 1'b0;
        b3.in_bus   = d;
        b3.in_mask  = m;
        b3.in_tag   = t;
        b3.in_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (b3.in_ready) begin
                e.acc = cyc + 1;
                e.tag = t;
                sb_q.push_back(e);
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        b3.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_rand();
        logic [639:0] w = rnd_bus();
        logic [7:0]   m = 8'($urandom);
        logic [7:0]   t = 8'($urandom);
        send(w[79:0], m, t, model({560'd0, w[79:0]}, {56'd0, m}, 8, t));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) @(negedge clk);
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb_on && rst_n && b3.out_valid && b3.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                chk_res("out", b3.out_idx, b3.out_min, b3.out_hit, b3.out_tag, e);
                if (lat_on) chk("latency", cyc - e.acc + 1, 3);
            end
        end
    end

    initial begin : wdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int p0;
        logic [639:0] w1, w3, w5;
        logic [63:0]  m1, m3, m5;
        exp_t e1, e3, e5;

        b1.in_valid = 0; b1.in_bus = '0; b1.in_mask = '0; b1.in_tag = '0; b1.out_ready = 1;
        b3.in_valid = 0; b3.in_bus = '0; b3.in_mask = '0; b3.in_tag = '0; b3.out_ready = 1;
        b5.in_valid = 0; b5.in_bus = '0; b5.in_mask = '0; b5.in_tag = '0; b5.out_ready = 1;

        #1;
        chk("rst0_ready", b3.in_ready, 1);
        chk("rst0_valid", b3.out_valid, 0);
        chk("rst0_out", {b3.out_idx, b3.out_min, b3.out_hit, b3.out_tag}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        sb_on = 1'b1;
        lat_on = 1'b1;
        send(pk(50, 40, 30, 20, 25, 60, 70, 90), 8'hFF, 8'h11, mk(3, 20, 1));
        send(pk(100, 100, 100, 100, 100, 100, 100, 100), 8'hFF, 8'h22, mk(0, 100, 1));
        send(pk(1, 1, 7, 1, 1, 7, 1, 1), 8'b0010_0100, 8'h33, mk(2, 7, 1));
        send(pk(0, 0, 0, 0, 0, 0, 0, 1023), 8'h80, 8'h44, mk(7, 1023, 1));
        send(pk(5, 6, 7, 8, 9, 10, 11, 12), 8'h00, 8'h55, mk(0, 1023, 0));
        drain();

        p0 = n_pop;
        repeat (20) send_rand();
        drain();
        chk("stream_count", n_pop - p0, 20);

        lat_on = 1'b0;
        p0 = n_pop;
        b3.out_ready = 1'b0;
        fork
            begin : bp_src
                repeat (4) send_rand();
            end
            begin : bp_obs
                bit seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = b3.out_valid;
                end
                chk("bp_first_valid", seen, 1);
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) @(negedge clk);
                    chk("bp_in_ready", b3.in_ready, 0);
                    chk("bp_out_valid", b3.out_valid, 1);
                    if (sb_q.size() > 0) begin
                        chk("bp_hold_idx", b3.out_idx, sb_q[0].idx);
                        chk("bp_hold_min", b3.out_min, sb_q[0].mn);
                        chk("bp_hold_tag", b3.out_tag, sb_q[0].tag);
                    end
                end
                @(posedge clk);
                #1;
                b3.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_pop - p0, 4);

        // Mid-stream reset on all three widths.
        sb_on = 1'b0;
        sb_q.delete();
        for (int b = 0; b < 2; b++) begin
            w1 = rnd_bus(); w3 = rnd_bus(); w5 = rnd_bus();
            b1.in_bus = w1[19:0];  b1.in_mask = 2'b11;  b1.in_tag = 8'hA0; b1.in_valid = 1;
            b3.in_bus = w3[79:0];  b3.in_mask = 8'hFF;  b3.in_tag = 8'hA1; b3.in_valid = 1;
            b5.in_bus = w5[319:0]; b5.in_mask = '1;     b5.in_tag = 8'hA2; b5.in_valid = 1;
            @(posedge clk);
            #1;
        end
        b1.in_valid = 0; b3.in_valid = 0; b5.in_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst1_vr", {b1.out_valid, b1.in_ready, b1.out_hit}, 3'b010);
        chk("mrst1_out", {b1.out_idx, b1.out_min, b1.out_tag}, 0);
        chk("mrst3_vr", {b3.out_valid, b3.in_ready, b3.out_hit}, 3'b010);
        chk("mrst3_out", {b3.out_idx, b3.out_min, b3.out_tag}, 0);
        chk("mrst5_vr", {b5.out_valid, b5.in_ready, b5.out_hit}, 3'b010);
        chk("mrst5_out", {b5.out_idx, b5.out_min, b5.out_tag}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        w1 = rnd_bus(); w3 = rnd_bus(); w5 = rnd_bus();
        m1 = {62'd0, 2'($urandom)};
        m3 = {56'd0, 8'($urandom)};
        m5 = {$urandom, $urandom};
        e1 = model(w1, m1, 2, 8'hB1);
        e3 = model(w3, m3, 8, 8'hB3);
        e5 = model(w5, m5, 32, 8'hB5);
        b1.in_bus = w1[19:0];  b1.in_mask = m1[1:0];  b1.in_tag = 8'hB1; b1.in_valid = 1;
        b3.in_bus = w3[79:0];  b3.in_mask = m3[7:0];  b3.in_tag = 8'hB3; b3.in_valid = 1;
        b5.in_bus = w5[319:0]; b5.in_mask = m5[31:0]; b5.in_tag = 8'hB5; b5.in_valid = 1;
        for (int s = 1; s <= 7; s++) begin
            @(posedge clk);
            #1;
            if (s == 1) begin
                b1.in_valid = 0; b3.in_valid = 0; b5.in_valid = 0;
            end
            chk("rel1_valid", b1.out_valid, (s == 1) ? 1 : 0);
            chk("rel3_valid", b3.out_valid, (s == 3) ? 1 : 0);
            chk("rel5_valid", b5.out_valid, (s == 5) ? 1 : 0);
            if (s == 1) chk_res("rel1", b1.out_idx, b1.out_min, b1.out_hit, b1.out_tag, e1);
            if (s == 3) chk_res("rel3", b3.out_idx, b3.out_min, b3.out_hit, b3.out_tag, e3);
            if (s == 5) chk_res("rel5", b5.out_idx, b5.out_min, b5.out_hit, b5.out_tag, e5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
